// File: rtl/muldiv_mc_ctrl_if.sv
`default_nettype none
// muldiv_mc_ctrl_if: EX-stage instruction, M-unit and writeback signals of the multicycle sequencer.
interface muldiv_mc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [6:0]      i_opcode;
  logic [6:0]      i_funct7;
  logic [2:0]      i_funct3;
  logic [4:0]      i_rd;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic [XLEN-1:0] o_mu_in1;
  logic [XLEN-1:0] o_mu_in2;
  logic [6:0]      o_mu_opcode;
  logic [6:0]      o_mu_funct7;
  logic [2:0]      o_mu_funct3;
  logic [XLEN-1:0] i_mu_result;
  logic            i_mu_muldiv;
  logic            o_stall;
  logic            o_wb_valid;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;

  modport master (
    output i_valid, i_opcode, i_funct7, i_funct3, i_rd, i_rs1, i_rs2, i_flush,
    output i_mu_result, i_mu_muldiv,
    input  o_mu_in1, o_mu_in2, o_mu_opcode, o_mu_funct7, o_mu_funct3,
    input  o_stall, o_wb_valid, o_wb_rd, o_wb_data
  );

  modport slave (
    input  i_valid, i_opcode, i_funct7, i_funct3, i_rd, i_rs1, i_rs2, i_flush,
    input  i_mu_result, i_mu_muldiv,
    output o_mu_in1, o_mu_in2, o_mu_opcode, o_mu_funct7, o_mu_funct3,
    output o_stall, o_wb_valid, o_wb_rd, o_wb_data
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_mc_ctrl.sv
`default_nettype none
// muldiv_mc_ctrl: sequences the combinational M-extension unit as a multicycle path,
// stalling EX for a per-class settle time and pulsing the captured result to writeback.
module muldiv_mc_ctrl #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input wire              i_clk,
  input wire              i_rst_n,
  muldiv_mc_ctrl_if.slave bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic            is_md;
  logic            accept;
  logic            capture;

  logic [XLEN-1:0] mu_in1;
  logic [XLEN-1:0] mu_in2;
  logic [6:0]      mu_opcode;
  logic [6:0]      mu_funct7;
  logic [2:0]      mu_funct3;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            unused_mu_muldiv;

  assign unused_mu_muldiv = bus.i_mu_muldiv;

  always_comb begin
    is_md     = bus.i_valid & (bus.i_opcode == OPC_OP) & (bus.i_funct7 == F7_MULDIV);
    // Gating with reset lets o_stall fall as soon as reset asserts, even with an M op parked in EX.
    accept    = is_md & ~bus.i_flush & (state == IDLE) & i_rst_n;
    capture   = (state == BUSY) & (cnt == 4'd0);
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = bus.i_funct3[2] ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (bus.i_flush) begin
          state_nxt = IDLE;
        end else if (capture) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand registers only load on accept so the unit inputs stay frozen for the whole settle window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mu_in1    <= '0;
      mu_in2    <= '0;
      mu_opcode <= 7'd0;
      mu_funct7 <= 7'd0;
      mu_funct3 <= 3'd0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
    end else begin
      if (accept) begin
        mu_in1    <= bus.i_rs1;
        mu_in2    <= bus.i_rs2;
        mu_opcode <= bus.i_opcode;
        mu_funct7 <= bus.i_funct7;
        mu_funct3 <= bus.i_funct3;
        wb_rd     <= bus.i_rd;
      end
      if (capture) begin
        wb_data <= bus.i_mu_result;
      end
    end
  end

  assign bus.o_mu_in1    = mu_in1;
  assign bus.o_mu_in2    = mu_in2;
  assign bus.o_mu_opcode = mu_opcode;
  assign bus.o_mu_funct7 = mu_funct7;
  assign bus.o_mu_funct3 = mu_funct3;
  assign bus.o_stall     = accept | (state == BUSY);
  assign bus.o_wb_valid  = (state == DONE) & ~bus.i_flush;
  assign bus.o_wb_rd     = wb_rd;
  assign bus.o_wb_data   = wb_data;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_mc_ctrl.sv
`default_nettype none
// tb_muldiv_mc_ctrl: directed plus randomized instruction stream against a cycle-stamped
// behavioural model; the M-unit stand-in only gives a correct result after its settle time.
module tb_muldiv_mc_ctrl;

  localparam int XLEN = 32;
  localparam int MULC = 2;
  localparam int DIVC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  muldiv_mc_ctrl_if #(.XLEN(XLEN)) bus ();

  muldiv_mc_ctrl #(
    .XLEN      (XLEN),
    .MUL_CYCLES(MULC),
    .DIV_CYCLES(DIVC)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return a * b;
      3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'd0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // M-unit stand-in: correct only once its inputs have been steady for the class settle time.
  logic [80:0] mu_prev   = '0;
  int          mu_stable = 100;
  always @(negedge clk) begin
    logic [80:0] cur;
    logic [31:0] r;
    int          need;
    cur = {bus.o_mu_in1, bus.o_mu_in2, bus.o_mu_opcode, bus.o_mu_funct7, bus.o_mu_funct3};
    if (cur !== mu_prev) mu_stable = 1;
    else if (mu_stable < 100) mu_stable++;
    mu_prev = cur;
    need = bus.o_mu_funct3[2] ? DIVC : MULC;
    r = ref_md(bus.o_mu_funct3, bus.o_mu_in1, bus.o_mu_in2);
    bus.i_mu_result = (mu_stable >= need) ? r : ~r;
    bus.i_mu_muldiv = 1'($urandom_range(0, 1));
  end

  // Reference model: one outstanding op stamped with its accept cycle.
  bit          m_active = 1'b0;
  int          m_issue  = 0;
  int          m_n      = 0;
  logic [31:0] m_res    = '0;
  logic [4:0]  m_rd     = '0;
  logic [31:0] e_in1 = '0, e_in2 = '0;
  logic [6:0]  e_op  = '0, e_f7  = '0;
  logic [2:0]  e_f3  = '0;

  always @(negedge clk) begin
    bit is_md;
    bit e_stall;
    bit e_wbv;
    int k;
    if (!rst_n) begin
      m_active = 1'b0;
      e_in1 = '0; e_in2 = '0; e_op = '0; e_f7 = '0; e_f3 = '0;
    end else begin
      is_md = bus.i_valid && bus.i_opcode == 7'h33 && bus.i_funct7 == 7'h01;
      k = cyc - m_issue;
      if (!m_active) begin
        e_stall = is_md && !bus.i_flush;
        e_wbv   = 1'b0;
      end else if (k <= m_n) begin
        e_stall = 1'b1;
        e_wbv   = 1'b0;
      end else begin
        e_stall = 1'b0;
        e_wbv   = !bus.i_flush;
      end
      chk("stall", 32'(bus.o_stall), 32'(e_stall));
      chk("wb_valid", 32'(bus.o_wb_valid), 32'(e_wbv));
      if (e_wbv) begin
        chk("wb_data", bus.o_wb_data, m_res);
        chk("wb_rd", 32'(bus.o_wb_rd), 32'(m_rd));
      end
      chk("mu_in1", bus.o_mu_in1, e_in1);
      chk("mu_in2", bus.o_mu_in2, e_in2);
      chk("mu_ctl", {15'd0, bus.o_mu_opcode, bus.o_mu_funct7, bus.o_mu_funct3}, {15'd0, e_op, e_f7, e_f3});
      if (!m_active && e_stall) begin
        m_active = 1'b1;
        m_issue  = cyc;
        m_n      = bus.i_funct3[2] ? DIVC : MULC;
        m_res    = ref_md(bus.i_funct3, bus.i_rs1, bus.i_rs2);
        m_rd     = bus.i_rd;
        e_in1 = bus.i_rs1; e_in2 = bus.i_rs2;
        e_op  = bus.i_opcode; e_f7 = bus.i_funct7; e_f3 = bus.i_funct3;
      end else if (m_active && (bus.i_flush || k > m_n)) begin
        m_active = 1'b0;
      end
    end
  end

  // Holds one instruction in EX until the stall drops; called and returns at posedge+1.
  task automatic run_instr(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, output int stalls,
                           output bit wbv, output logic [31:0] wbd, output logic [4:0] wbr,
                           output int wcyc);
    bus.i_valid  = 1'b1;
    bus.i_opcode = 7'h33;
    bus.i_funct7 = f7;
    bus.i_funct3 = f3;
    bus.i_rs1    = a;
    bus.i_rs2    = b;
    bus.i_rd     = rd;
    bus.i_flush  = 1'b0;
    stalls = 0; wbv = 1'b0; wbd = '0; wbr = '0; wcyc = -1;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (bus.o_stall) stalls++;
      else begin
        wbv = bus.o_wb_valid; wbd = bus.o_wb_data; wbr = bus.o_wb_rd; wcyc = cyc;
        break;
      end
    end
    if (wcyc < 0) begin
      n_total++;
      $display("FAIL run_timeout: stall still high after %0d cycles, required release", stalls);
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle(input int n);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic pick_instr();
    int kind;
    kind = $urandom_range(0, 9);
    bus.i_valid  = ($urandom_range(0, 7) != 0);
    bus.i_opcode = (kind == 8) ? 7'h13 : 7'h33;
    bus.i_funct7 = (kind == 7) ? 7'h00 : (kind == 9) ? 7'h20 : 7'h01;
    bus.i_funct3 = 3'($urandom_range(0, 7));
    bus.i_rs1    = rnd_opnd();
    bus.i_rs2    = rnd_opnd();
    bus.i_rd     = 5'($urandom_range(0, 31));
  endtask

  initial begin
    int          st;
    int          wc1;
    int          wc2;
    int          nwb;
    bit          wv;
    logic [31:0] wd;
    logic [4:0]  wr;
    bit          last_stall;
    bit          last_flush;

    bus.i_valid = 1'b0; bus.i_opcode = '0; bus.i_funct7 = '0; bus.i_funct3 = '0;
    bus.i_rd = '0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_flush = 1'b0;

    @(posedge clk); #1;
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_wb_valid", 32'(bus.o_wb_valid), 32'd0);
    chk("rst_mu_in1", bus.o_mu_in1, 32'd0);
    chk("rst_wb_data", bus.o_wb_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("ref_mul", ref_md(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("ref_div_ovf", ref_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("ref_rem_ovf", ref_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    chk("ref_mulhu", ref_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("ref_divu", ref_md(3'd5, 32'd100, 32'd7), 32'd14);
    chk("ref_remu", ref_md(3'd7, 32'd100, 32'd7), 32'd2);

    run_instr(7'h01, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, st, wv, wd, wr, wc1);
    chk("mul_stall_cycles", 32'(st), 32'd3);
    chk("mul_wb_valid", 32'(wv), 32'd1);
    chk("mul_wb_data", wd, 32'hFFFF_FFEB);
    chk("mul_wb_rd", 32'(wr), 32'd5);
    go_idle(2);

    run_instr(7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, st, wv, wd, wr, wc1);
    chk("div_stall_cycles", 32'(st), 32'd5);
    chk("div_wb_data", wd, 32'h8000_0000);
    run_instr(7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, st, wv, wd, wr, wc1);
    chk("rem_wb_data", wd, 32'd0);
    chk("rem_wb_rd", 32'(wr), 32'd10);

    run_instr(7'h00, 3'd0, 32'h1234_5678, 32'd1, 5'd3, st, wv, wd, wr, wc1);
    chk("add_stall", 32'(st), 32'd0);
    chk("add_wb_valid", 32'(wv), 32'd0);
    chk("add_mu_funct3", 32'(bus.o_mu_funct3), 32'd6);
    go_idle(1);

    bus.i_valid = 1'b1; bus.i_opcode = 7'h33; bus.i_funct7 = 7'h01; bus.i_funct3 = 3'd5;
    bus.i_rs1 = 32'd100; bus.i_rs2 = 32'd7; bus.i_rd = 5'd4;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("flush_stall_drop", 32'(bus.o_stall), 32'd0);
    nwb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_wb_valid) nwb++;
    end
    chk("flush_no_wb", 32'(nwb), 32'd0);
    @(posedge clk); #1;

    run_instr(7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, st, wv, wd, wr, wc1);
    chk("mulhu_wb_data", wd, 32'hFFFF_FFFE);
    go_idle(1);

    run_instr(7'h01, 3'd5, 32'd100, 32'd7, 5'd12, st, wv, wd, wr, wc1);
    chk("b2b_divu_data", wd, 32'd14);
    run_instr(7'h01, 3'd7, 32'd100, 32'd7, 5'd13, st, wv, wd, wr, wc2);
    chk("b2b_remu_data", wd, 32'd2);
    chk("b2b_gap", 32'(wc2 - wc1), 32'd6);
    go_idle(1);

    bus.i_valid = 1'b1; bus.i_opcode = 7'h33; bus.i_funct7 = 7'h01; bus.i_funct3 = 3'd0;
    bus.i_rs1 = 32'hDEAD_BEEF; bus.i_rs2 = 32'h0000_0003; bus.i_rd = 5'd7;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(bus.o_stall), 32'd0);
    chk("arst_wb_valid", 32'(bus.o_wb_valid), 32'd0);
    chk("arst_mu_in1", bus.o_mu_in1, 32'd0);
    chk("arst_mu_in2", bus.o_mu_in2, 32'd0);
    chk("arst_mu_ctl", {15'd0, bus.o_mu_opcode, bus.o_mu_funct7, bus.o_mu_funct3}, 32'd0);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(7'h01, 3'd0, 32'd3, 32'd4, 5'd1, st, wv, wd, wr, wc1);
    chk("post_rst_stall", 32'(st), 32'd3);
    chk("post_rst_data", wd, 32'd12);

    last_stall = 1'b0;
    last_flush = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall || last_flush) pick_instr();
      bus.i_flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      last_stall = bus.o_stall;
      last_flush = bus.i_flush;
      @(posedge clk); #1;
    end
    go_idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
